// File: rtl/input_p4_demux_pkg.sv
// Shared types and helpers for the input_p4_demux ingress steering block.
package input_p4_demux_pkg;

    localparam int unsigned MAX_QUEUES = 8;
    localparam int unsigned IDX_W      = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

    // Increment v, holding at the all-ones value of a w-bit counter (w <= 64).
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] max_v;
        max_v = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        return (v >= max_v) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/demux_out_reg.sv
// One-entry AXI4-Stream register slice feeding a single virtual-switch output.
module demux_out_reg #(
    parameter int unsigned DW = 256,
    parameter int unsigned UW = 304
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr,
    input  logic [DW-1:0]   wr_data,
    input  logic [DW/8-1:0] wr_keep,
    input  logic [UW-1:0]   wr_user,
    input  logic            wr_last,
    output logic            rdy_c,
    output logic [DW-1:0]   tdata,
    output logic [DW/8-1:0] tkeep,
    output logic [UW-1:0]   tuser,
    output logic            tvalid,
    output logic            tlast,
    input  logic            tready
);

    assign rdy_c = ~tvalid | tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tvalid <= 1'b0;
        end else if (wr) begin
            tvalid <= 1'b1;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end

    // Payload needs no reset; it is only observed while tvalid is set.
    always_ff @(posedge clk) begin
        if (wr) begin
            tdata <= wr_data;
            tkeep <= wr_keep;
            tuser <= wr_user;
            tlast <= wr_last;
        end
    end

endmodule

// File: rtl/input_p4_demux.sv
// Steers whole AXIS packets to one of NUM_QUEUES virtual switches by the tuser ID.
// Eight output port sets exist; those at or above NUM_QUEUES stay idle. Macro: INPUT_P4_DEMUX_STATS_EN.
module input_p4_demux
    import input_p4_demux_pkg::*;
#(
    parameter int unsigned NUM_QUEUES           = 5,
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_M_AXIS_TUSER_WIDTH = 304,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 304,
    parameter int unsigned SEL_LSB              = 32,
    parameter int unsigned SEL_WIDTH            = 3,
    parameter int unsigned CNT_WIDTH            = 32
) (
    input  logic                                axis_aclk,
    input  logic                                axis_reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    input  logic                                s_axis_tlast,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_0_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_0_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_0_tuser,
    output logic                                m_axis_0_tvalid,
    output logic                                m_axis_0_tlast,
    input  logic                                m_axis_0_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_1_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_1_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_1_tuser,
    output logic                                m_axis_1_tvalid,
    output logic                                m_axis_1_tlast,
    input  logic                                m_axis_1_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_2_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_2_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_2_tuser,
    output logic                                m_axis_2_tvalid,
    output logic                                m_axis_2_tlast,
    input  logic                                m_axis_2_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_3_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_3_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_3_tuser,
    output logic                                m_axis_3_tvalid,
    output logic                                m_axis_3_tlast,
    input  logic                                m_axis_3_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_4_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_4_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_4_tuser,
    output logic                                m_axis_4_tvalid,
    output logic                                m_axis_4_tlast,
    input  logic                                m_axis_4_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_5_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_5_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_5_tuser,
    output logic                                m_axis_5_tvalid,
    output logic                                m_axis_5_tlast,
    input  logic                                m_axis_5_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_6_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_6_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_6_tuser,
    output logic                                m_axis_6_tvalid,
    output logic                                m_axis_6_tlast,
    input  logic                                m_axis_6_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_7_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_7_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_7_tuser,
    output logic                                m_axis_7_tvalid,
    output logic                                m_axis_7_tlast,
    input  logic                                m_axis_7_tready,
    output logic [CNT_WIDTH-1:0]                drop_cnt,
    output logic                                pkt_in
`ifdef INPUT_P4_DEMUX_STATS_EN
    ,
    output logic [NUM_QUEUES*CNT_WIDTH-1:0]     pkt_cnt
`endif
);

    localparam int unsigned DW = C_M_AXIS_DATA_WIDTH;
    localparam int unsigned KW = C_M_AXIS_DATA_WIDTH / 8;
    localparam int unsigned UW = C_M_AXIS_TUSER_WIDTH;

    state_t                 state, state_nx;
    logic [IDX_W-1:0]       sel, sel_nx;
    logic [SEL_WIDTH-1:0]   id;
    logic [IDX_W-1:0]       id_idx;
    logic                   hit;
    logic                   tready_c;
    logic                   pkt_in_nx;
    logic                   drop_inc;
    logic [MAX_QUEUES-1:0]  wr_en;
    logic [MAX_QUEUES-1:0]  out_rdy;
    logic [MAX_QUEUES-1:0]  q_tvalid, q_tlast, q_tready;
    logic [DW-1:0]          q_tdata [MAX_QUEUES];
    logic [KW-1:0]          q_tkeep [MAX_QUEUES];
    logic [UW-1:0]          q_tuser [MAX_QUEUES];

    assign id            = s_axis_tuser[SEL_LSB +: SEL_WIDTH];
    assign id_idx        = IDX_W'(id);
    assign hit           = (32'(id) < 32'(NUM_QUEUES));
    assign s_axis_tready = tready_c;

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            state    <= IDLE;
            sel      <= '0;
            pkt_in   <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state  <= state_nx;
            sel    <= sel_nx;
            pkt_in <= pkt_in_nx;
            if (drop_inc) begin
                drop_cnt <= CNT_WIDTH'(sat_inc(64'(drop_cnt), CNT_WIDTH));
            end
        end
    end

    // Packet-level steering: the ID is only examined on the first beat.
    always_comb begin
        state_nx  = state;
        sel_nx    = sel;
        tready_c  = 1'b0;
        wr_en     = '0;
        pkt_in_nx = 1'b0;
        drop_inc  = 1'b0;
        case (state)
            IDLE: begin
                tready_c = hit ? out_rdy[id_idx] : 1'b1;
                if (s_axis_tvalid && tready_c) begin
                    pkt_in_nx = 1'b1;
                    if (hit) begin
                        wr_en[id_idx] = 1'b1;
                        sel_nx        = id_idx;
                        if (!s_axis_tlast) state_nx = FWD;
                    end else if (s_axis_tlast) begin
                        drop_inc = 1'b1;
                    end else begin
                        state_nx = DROP;
                    end
                end
            end
            FWD: begin
                tready_c = out_rdy[sel];
                if (s_axis_tvalid && tready_c) begin
                    wr_en[sel] = 1'b1;
                    if (s_axis_tlast) state_nx = IDLE;
                end
            end
            DROP: begin
                tready_c = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    drop_inc = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    for (genvar i = 0; i < int'(MAX_QUEUES); i++) begin : g_out
        demux_out_reg #(.DW(DW), .UW(UW)) u_reg (
            .clk     (axis_aclk),
            .rst     (axis_reset),
            .wr      (wr_en[i]),
            .wr_data (s_axis_tdata),
            .wr_keep (s_axis_tkeep),
            .wr_user (s_axis_tuser),
            .wr_last (s_axis_tlast),
            .rdy_c   (out_rdy[i]),
            .tdata   (q_tdata[i]),
            .tkeep   (q_tkeep[i]),
            .tuser   (q_tuser[i]),
            .tvalid  (q_tvalid[i]),
            .tlast   (q_tlast[i]),
            .tready  (q_tready[i])
        );
    end

`ifdef INPUT_P4_DEMUX_STATS_EN
    // Per-output forwarded-packet counters, bumped on the input tlast handshake.
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            pkt_cnt <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_QUEUES); i++) begin
                if (wr_en[i] && s_axis_tlast) begin
                    pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH] <=
                        CNT_WIDTH'(sat_inc(64'(pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH]), CNT_WIDTH));
                end
            end
        end
    end
`endif

    assign q_tready = {m_axis_7_tready, m_axis_6_tready, m_axis_5_tready, m_axis_4_tready,
                       m_axis_3_tready, m_axis_2_tready, m_axis_1_tready, m_axis_0_tready};

    assign {m_axis_7_tvalid, m_axis_6_tvalid, m_axis_5_tvalid, m_axis_4_tvalid,
            m_axis_3_tvalid, m_axis_2_tvalid, m_axis_1_tvalid, m_axis_0_tvalid} = q_tvalid;
    assign {m_axis_7_tlast, m_axis_6_tlast, m_axis_5_tlast, m_axis_4_tlast,
            m_axis_3_tlast, m_axis_2_tlast, m_axis_1_tlast, m_axis_0_tlast} = q_tlast;

    assign m_axis_0_tdata = q_tdata[0];
    assign m_axis_1_tdata = q_tdata[1];
    assign m_axis_2_tdata = q_tdata[2];
    assign m_axis_3_tdata = q_tdata[3];
    assign m_axis_4_tdata = q_tdata[4];
    assign m_axis_5_tdata = q_tdata[5];
    assign m_axis_6_tdata = q_tdata[6];
    assign m_axis_7_tdata = q_tdata[7];
    assign m_axis_0_tkeep = q_tkeep[0];
    assign m_axis_1_tkeep = q_tkeep[1];
    assign m_axis_2_tkeep = q_tkeep[2];
    assign m_axis_3_tkeep = q_tkeep[3];
    assign m_axis_4_tkeep = q_tkeep[4];
    assign m_axis_5_tkeep = q_tkeep[5];
    assign m_axis_6_tkeep = q_tkeep[6];
    assign m_axis_7_tkeep = q_tkeep[7];
    assign m_axis_0_tuser = q_tuser[0];
    assign m_axis_1_tuser = q_tuser[1];
    assign m_axis_2_tuser = q_tuser[2];
    assign m_axis_3_tuser = q_tuser[3];
    assign m_axis_4_tuser = q_tuser[4];
    assign m_axis_5_tuser = q_tuser[5];
    assign m_axis_6_tuser = q_tuser[6];
    assign m_axis_7_tuser = q_tuser[7];

endmodule

// File: tb/tb_input_p4_demux.sv
// Directed, table-driven bench for input_p4_demux with the default five outputs.
module tb_input_p4_demux;
    import input_p4_demux_pkg::*;

    logic         axis_aclk;
    logic         axis_reset;
    logic [255:0] s_tdata;
    logic [31:0]  s_tkeep;
    logic [303:0] s_tuser;
    logic         s_tvalid, s_tready, s_tlast;
    logic [255:0] m_tdata [8];
    logic [31:0]  m_tkeep [8];
    logic [303:0] m_tuser [8];
    logic [7:0]   m_tvalid, m_tlast, m_tready;
    logic [31:0]  drop_cnt;
    logic         pkt_in;
`ifdef INPUT_P4_DEMUX_STATS_EN
    logic [159:0] pkt_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       vld;
        logic       last;
        logic [7:0] tag;
        logic [2:0] id;
        logic [7:0] rdy;
        logic       exp_srdy;
        logic [7:0] exp_v;
        logic       exp_pkt;
        int         exp_drop;
        int         port;
        logic [7:0] exp_tag;
        logic       exp_last;
        logic [2:0] exp_id;
    } vec_t;

    vec_t vecs[$];

    input_p4_demux dut (
        .axis_aclk(axis_aclk), .axis_reset(axis_reset),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_0_tdata(m_tdata[0]), .m_axis_0_tkeep(m_tkeep[0]), .m_axis_0_tuser(m_tuser[0]),
        .m_axis_0_tvalid(m_tvalid[0]), .m_axis_0_tlast(m_tlast[0]), .m_axis_0_tready(m_tready[0]),
        .m_axis_1_tdata(m_tdata[1]), .m_axis_1_tkeep(m_tkeep[1]), .m_axis_1_tuser(m_tuser[1]),
        .m_axis_1_tvalid(m_tvalid[1]), .m_axis_1_tlast(m_tlast[1]), .m_axis_1_tready(m_tready[1]),
        .m_axis_2_tdata(m_tdata[2]), .m_axis_2_tkeep(m_tkeep[2]), .m_axis_2_tuser(m_tuser[2]),
        .m_axis_2_tvalid(m_tvalid[2]), .m_axis_2_tlast(m_tlast[2]), .m_axis_2_tready(m_tready[2]),
        .m_axis_3_tdata(m_tdata[3]), .m_axis_3_tkeep(m_tkeep[3]), .m_axis_3_tuser(m_tuser[3]),
        .m_axis_3_tvalid(m_tvalid[3]), .m_axis_3_tlast(m_tlast[3]), .m_axis_3_tready(m_tready[3]),
        .m_axis_4_tdata(m_tdata[4]), .m_axis_4_tkeep(m_tkeep[4]), .m_axis_4_tuser(m_tuser[4]),
        .m_axis_4_tvalid(m_tvalid[4]), .m_axis_4_tlast(m_tlast[4]), .m_axis_4_tready(m_tready[4]),
        .m_axis_5_tdata(m_tdata[5]), .m_axis_5_tkeep(m_tkeep[5]), .m_axis_5_tuser(m_tuser[5]),
        .m_axis_5_tvalid(m_tvalid[5]), .m_axis_5_tlast(m_tlast[5]), .m_axis_5_tready(m_tready[5]),
        .m_axis_6_tdata(m_tdata[6]), .m_axis_6_tkeep(m_tkeep[6]), .m_axis_6_tuser(m_tuser[6]),
        .m_axis_6_tvalid(m_tvalid[6]), .m_axis_6_tlast(m_tlast[6]), .m_axis_6_tready(m_tready[6]),
        .m_axis_7_tdata(m_tdata[7]), .m_axis_7_tkeep(m_tkeep[7]), .m_axis_7_tuser(m_tuser[7]),
        .m_axis_7_tvalid(m_tvalid[7]), .m_axis_7_tlast(m_tlast[7]), .m_axis_7_tready(m_tready[7]),
        .drop_cnt(drop_cnt),
        .pkt_in(pkt_in)
`ifdef INPUT_P4_DEMUX_STATS_EN
        , .pkt_cnt(pkt_cnt)
`endif
    );

    initial axis_aclk = 1'b0;
    always #5 axis_aclk = ~axis_aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic vld, input logic last, input logic [7:0] tag,
                                input logic [2:0] id, input logic [7:0] rdy, input logic srdy,
                                input logic [7:0] ev, input logic pkt, input int drop,
                                input int port, input logic [7:0] etag, input logic elast,
                                input logic [2:0] eid);
        vec_t v;
        v.vld = vld; v.last = last; v.tag = tag; v.id = id; v.rdy = rdy;
        v.exp_srdy = srdy; v.exp_v = ev; v.exp_pkt = pkt; v.exp_drop = drop;
        v.port = port; v.exp_tag = etag; v.exp_last = elast; v.exp_id = eid;
        return v;
    endfunction

    task automatic drive(input logic vld, input logic last, input logic [7:0] tag,
                         input logic [2:0] id, input logic [7:0] rdy);
        s_tvalid        = vld;
        s_tlast         = last;
        s_tdata         = 256'(tag);
        s_tkeep         = {4{tag}};
        s_tuser         = '0;
        s_tuser[34:32]  = id;
        m_tready        = rdy;
    endtask

    // Apply one vector for one cycle, then check the registered result after the edge.
    task automatic run_vec(input vec_t v, input int k);
        drive(v.vld, v.last, v.tag, v.id, v.rdy);
        #1;
        chk($sformatf("v%0d s_tready", k), 64'(s_tready), 64'(v.exp_srdy));
        @(posedge axis_aclk);
        #1;
        chk($sformatf("v%0d tvalid", k), 64'(m_tvalid), 64'(v.exp_v));
        chk($sformatf("v%0d pkt_in", k), 64'(pkt_in), 64'(v.exp_pkt));
        chk($sformatf("v%0d drop_cnt", k), 64'(drop_cnt), 64'(v.exp_drop));
        if (v.port >= 0) begin
            chk($sformatf("v%0d tdata", k), m_tdata[v.port][63:0], 64'(v.exp_tag));
            chk($sformatf("v%0d tkeep", k), 64'(m_tkeep[v.port]), 64'({4{v.exp_tag}}));
            chk($sformatf("v%0d tlast", k), 64'(m_tlast[v.port]), 64'(v.exp_last));
            chk($sformatf("v%0d tuser_id", k), 64'(m_tuser[v.port][34:32]), 64'(v.exp_id));
        end
    endtask

    initial begin
        axis_reset = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 3'd0, 8'hFF);

        // Single beat to output 2, then idle
        vecs.push_back(mk(1,1,8'h10,3'd2,8'hFF, 1,8'h04,1,0, 2,8'h10,1,3'd2));
        vecs.push_back(mk(0,0,8'h00,3'd0,8'hFF, 1,8'h00,0,0, -1,8'h00,0,3'd0));
        // Four beats to output 1 with its ready low for three cycles
        vecs.push_back(mk(1,0,8'h21,3'd1,8'hFF, 1,8'h02,1,0, 1,8'h21,0,3'd1));
        vecs.push_back(mk(1,0,8'h22,3'd1,8'hFD, 0,8'h02,0,0, 1,8'h21,0,3'd1));
        vecs.push_back(mk(1,0,8'h22,3'd1,8'hFD, 0,8'h02,0,0, 1,8'h21,0,3'd1));
        vecs.push_back(mk(1,0,8'h22,3'd1,8'hFD, 0,8'h02,0,0, 1,8'h21,0,3'd1));
        vecs.push_back(mk(1,0,8'h22,3'd1,8'hFF, 1,8'h02,0,0, 1,8'h22,0,3'd1));
        vecs.push_back(mk(1,0,8'h23,3'd1,8'hFF, 1,8'h02,0,0, 1,8'h23,0,3'd1));
        vecs.push_back(mk(1,1,8'h24,3'd1,8'hFF, 1,8'h02,0,0, 1,8'h24,1,3'd1));
        vecs.push_back(mk(0,0,8'h00,3'd0,8'hFF, 1,8'h00,0,0, -1,8'h00,0,3'd0));
        // Three-beat drop with id 7 (ready ignored), then single-beat drop with id 5
        vecs.push_back(mk(1,0,8'h31,3'd7,8'hFF, 1,8'h00,1,0, -1,8'h00,0,3'd0));
        vecs.push_back(mk(1,0,8'h32,3'd7,8'h00, 1,8'h00,0,0, -1,8'h00,0,3'd0));
        vecs.push_back(mk(1,1,8'h33,3'd7,8'hFF, 1,8'h00,0,1, -1,8'h00,0,3'd0));
        vecs.push_back(mk(1,1,8'h35,3'd5,8'hFF, 1,8'h00,1,2, -1,8'h00,0,3'd0));
        // Back-to-back id 0 then id 4 with no gap
        vecs.push_back(mk(1,0,8'h41,3'd0,8'hFF, 1,8'h01,1,2, 0,8'h41,0,3'd0));
        vecs.push_back(mk(1,1,8'h42,3'd0,8'hFF, 1,8'h01,0,2, 0,8'h42,1,3'd0));
        vecs.push_back(mk(1,0,8'h43,3'd4,8'hFF, 1,8'h10,1,2, 4,8'h43,0,3'd4));
        vecs.push_back(mk(1,1,8'h44,3'd4,8'hFF, 1,8'h10,0,2, 4,8'h44,1,3'd4));
        vecs.push_back(mk(0,0,8'h00,3'd0,8'hFF, 1,8'h00,0,2, -1,8'h00,0,3'd0));
        // id 3 packet whose second beat carries id 0 in tuser
        vecs.push_back(mk(1,0,8'h51,3'd3,8'hFF, 1,8'h08,1,2, 3,8'h51,0,3'd3));
        vecs.push_back(mk(1,1,8'h52,3'd0,8'hFF, 1,8'h08,0,2, 3,8'h52,1,3'd0));
        vecs.push_back(mk(0,0,8'h00,3'd0,8'hFF, 1,8'h00,0,2, -1,8'h00,0,3'd0));
        // First beat blocked by a full, stalled destination
        vecs.push_back(mk(1,1,8'h71,3'd2,8'hFB, 1,8'h04,1,2, 2,8'h71,1,3'd2));
        vecs.push_back(mk(1,1,8'h72,3'd2,8'hFB, 0,8'h04,0,2, 2,8'h71,1,3'd2));
        vecs.push_back(mk(1,1,8'h72,3'd2,8'hFF, 1,8'h04,1,2, 2,8'h72,1,3'd2));
        vecs.push_back(mk(0,0,8'h00,3'd0,8'hFF, 1,8'h00,0,2, -1,8'h00,0,3'd0));

        repeat (2) @(posedge axis_aclk);
        #1;
        chk("reset tvalid", 64'(m_tvalid), 64'h0);
        chk("reset pkt_in", 64'(pkt_in), 64'h0);
        chk("reset drop_cnt", 64'(drop_cnt), 64'h0);
        axis_reset = 1'b0;

        for (int k = 0; k < vecs.size(); k++) run_vec(vecs[k], k);

        // Reset during beat 2 of a five-beat packet to output 2
        run_vec(mk(1,0,8'h61,3'd2,8'hFF, 1,8'h04,1,2, 2,8'h61,0,3'd2), 100);
        drive(1'b1, 1'b0, 8'h62, 3'd2, 8'hFF);
        #2;
        axis_reset = 1'b1;
        #1;
        chk("midpkt reset tvalid", 64'(m_tvalid), 64'h0);
        chk("midpkt reset pkt_in", 64'(pkt_in), 64'h0);
        chk("midpkt reset drop_cnt", 64'(drop_cnt), 64'h0);
        @(negedge axis_aclk);
        axis_reset = 1'b0;
        run_vec(mk(1,0,8'h62,3'd1,8'hFF, 1,8'h02,1,0, 1,8'h62,0,3'd1), 101);
        run_vec(mk(1,0,8'h63,3'd3,8'hFF, 1,8'h02,0,0, 1,8'h63,0,3'd3), 102);
        run_vec(mk(1,1,8'h64,3'd4,8'hFF, 1,8'h02,0,0, 1,8'h64,1,3'd4), 103);
        run_vec(mk(0,0,8'h00,3'd0,8'hFF, 1,8'h00,0,0, -1,8'h00,0,3'd0), 104);

        // Saturating increment helper at its limits
        chk("sat_inc below max", sat_inc(64'd2, 2), 64'd3);
        chk("sat_inc at max", sat_inc(64'd3, 2), 64'd3);
        chk("sat_inc 32b max", sat_inc(64'hFFFF_FFFF, 32), 64'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
